// File: rtl/cpu_state_dump.sv
// Streams PC then R0..R(NREGS-1) over a valid/ready beat stream when dump_req_i is seen in IDLE.
// Optional XOR checksum beat (tag 9) is enabled by defining CPU_DUMP_CHECKSUM_EN.
module cpu_state_dump #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int NREGS  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     dump_req_i,
  input  logic [PC_W-1:0]          pc_in_i,
  output logic [$clog2(NREGS)-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0]        rf_rdata_i,
  output logic                     dout_valid_o,
  input  logic                     dout_ready_i,
  output logic [DATA_W-1:0]        dout_data_o,
  output logic [3:0]               dout_tag_o,
  output logic                     dout_last_o,
  output logic                     busy_o
);
  localparam int         IDX_W    = $clog2(NREGS);
  localparam int         CNT_W    = IDX_W + 1;
  localparam logic [3:0] TAG_PC   = 4'd8;
`ifdef CPU_DUMP_CHECKSUM_EN
  localparam logic [3:0] TAG_CSUM = 4'd9;
  localparam bit         CSUM_EN  = 1'b1;
`else
  localparam bit         CSUM_EN  = 1'b0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        tag_q, tag_d;
  logic              last_q, last_d;
  logic              xfer;
`ifdef CPU_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              reg_beat_next;

  // cnt_q reaches NREGS only after the last register beat has been loaded
  assign reg_beat_next = cnt_q < CNT_W'(NREGS);
`endif

  assign xfer = (state_q == SEND) && dout_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dump_req_i) state_d = SEND;
      SEND:    if (xfer && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_valid_o = (state_q == SEND);
    busy_o       = (state_q == SEND);
    rf_raddr_o   = cnt_q[IDX_W-1:0];
    dout_data_o  = data_q;
    dout_tag_o   = tag_q;
    dout_last_o  = last_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    tag_d  = tag_q;
    last_d = last_q;
`ifdef CPU_DUMP_CHECKSUM_EN
    csum_d = csum_q;
`endif
    if (state_q == IDLE) begin
      if (dump_req_i) begin
        data_d = DATA_W'(pc_in_i);
        tag_d  = TAG_PC;
        last_d = 1'b0;
        cnt_d  = '0;
`ifdef CPU_DUMP_CHECKSUM_EN
        csum_d = DATA_W'(pc_in_i);
`endif
      end
    end else if (xfer) begin
      if (last_q) begin
        last_d = 1'b0;
        cnt_d  = '0;
`ifdef CPU_DUMP_CHECKSUM_EN
      end else if (reg_beat_next) begin
`else
      end else begin
`endif
        data_d = rf_rdata_i;
        tag_d  = 4'(cnt_q[IDX_W-1:0]);
        last_d = (cnt_q == CNT_W'(NREGS - 1)) && !CSUM_EN;
        cnt_d  = cnt_q + CNT_W'(1);
`ifdef CPU_DUMP_CHECKSUM_EN
        csum_d = csum_q ^ rf_rdata_i;
      end else begin
        data_d = csum_q;
        tag_d  = TAG_CSUM;
        last_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      data_q <= '0;
      tag_q  <= '0;
      last_q <= 1'b0;
`ifdef CPU_DUMP_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      tag_q  <= tag_d;
      last_q <= last_d;
`ifdef CPU_DUMP_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_state_dump.sv
// Randomized bench for cpu_state_dump; expected beat lists come from a list-level model of the dump.
module tb_cpu_state_dump;
  localparam int DW = 16;
  localparam int PW = 16;
  localparam int NR = 8;
`ifdef CPU_DUMP_CHECKSUM_EN
  localparam int NB = NR + 2;
`else
  localparam int NB = NR + 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          dump_req;
  logic [PW-1:0] pc_in;
  logic [2:0]    rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] dout_data;
  logic [3:0]    dout_tag;
  logic          dout_last;
  logic          busy;
  logic [DW-1:0] rf [NR];

  typedef struct packed {
    logic [3:0]    tag;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t got[$];
  int    got_cyc[$];
  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    hold_err = 0;
  int    mode = 0;
  int    pat = 0;
  logic  prev_hold = 1'b0;
  beat_t prev_b;

  cpu_state_dump #(.DATA_W(DW), .PC_W(PW), .NREGS(NR)) dut (
    .clk_i(clk), .rst_i(rst), .dump_req_i(dump_req), .pc_in_i(pc_in),
    .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata), .dout_valid_o(dout_valid),
    .dout_ready_i(dout_ready), .dout_data_o(dout_data), .dout_tag_o(dout_tag),
    .dout_last_o(dout_last), .busy_o(busy)
  );

  assign rf_rdata = rf[rf_raddr];
  always #5 clk = ~clk;

  // Transfers are recorded at the falling edge preceding the rising edge that completes them.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (!dout_valid || dout_tag !== prev_b.tag ||
                        dout_data !== prev_b.data || dout_last !== prev_b.last))
        hold_err++;
      if (dout_valid && dout_ready) begin
        got.push_back('{dout_tag, dout_data, dout_last});
        got_cyc.push_back(cyc);
      end
      prev_hold = dout_valid && !dout_ready;
      prev_b    = '{dout_tag, dout_data, dout_last};
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
    pat++;
    case (mode)
      1:       dout_ready = (pat % 4 == 0) || (pat % 4 == 3);
      2:       dout_ready = 1'($urandom_range(0, 1));
      default: dout_ready = 1'b1;
    endcase
  endtask

  function automatic void build_exp(input logic [PW-1:0] pc);
    logic [DW-1:0] x;
    exp_q.delete();
    exp_q.push_back('{4'd8, DW'(pc), 1'b0});
    for (int i = 0; i < NR; i++) exp_q.push_back('{4'(i), rf[i], 1'b0});
    x = '0;
    foreach (exp_q[i]) x ^= exp_q[i].data;
`ifdef CPU_DUMP_CHECKSUM_EN
    exp_q.push_back('{4'd9, x, 1'b0});
`endif
    exp_q[exp_q.size()-1].last = 1'b1;
  endfunction

  task automatic randomize_rf();
    for (int i = 0; i < NR; i++) rf[i] = DW'($urandom);
  endtask

  task automatic do_dump(input logic [PW-1:0] pc, output bit timed_out);
    int n = 0;
    pc_in = pc;
    build_exp(pc);
    got.delete();
    got_cyc.delete();
    dump_req = 1'b1;
    wait_cycle();
    dump_req = 1'b0;
    while (busy && n < 400) begin
      wait_cycle();
      n++;
    end
    timed_out = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; dump_req = 1'b0; pc_in = '0; dout_ready = 1'b1;
    for (int i = 0; i < NR; i++) rf[i] = '0;
    #3;
    checks += 6;
    if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (dout_last !== 1'b0)  begin failures++; $display("FAIL reset_last got=%b exp=0", dout_last); end
    if (dout_data !== '0)    begin failures++; $display("FAIL reset_data got=%h exp=0", dout_data); end
    if (dout_tag !== 4'd0)   begin failures++; $display("FAIL reset_tag got=%h exp=0", dout_tag); end
    if (rf_raddr !== 3'd0)   begin failures++; $display("FAIL reset_raddr got=%h exp=0", rf_raddr); end
    wait_cycle();
    wait_cycle();
    rst = 1'b0;
    wait_cycle();
  endtask

  task automatic test_basic();
    int n = 0;
    mode = 0;
    for (int i = 0; i < NR; i++) rf[i] = 16'h1000 + DW'(i);
    pc_in = 16'h0024;
    build_exp(pc_in);
    got.delete();
    got_cyc.delete();
    dump_req = 1'b1;
    wait_cycle();
    dump_req = 1'b0;
    checks += 3;
    if (dout_valid !== 1'b1) begin failures++; $display("FAIL basic_latency_valid got=%b exp=1", dout_valid); end
    if (dout_tag !== 4'd8)   begin failures++; $display("FAIL basic_latency_tag got=%h exp=8", dout_tag); end
    if (rf_raddr !== 3'd0)   begin failures++; $display("FAIL basic_pc_raddr got=%h exp=0", rf_raddr); end
    while (busy && n < 400) begin wait_cycle(); n++; end
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", busy); end
    if (got.size() !== NB) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got.size(), NB); end
    if (got.size() == NB && (got_cyc[NB-1] - got_cyc[0]) !== NB - 1) begin
      failures++; $display("FAIL basic_throughput got=%0d exp=%0d", got_cyc[NB-1] - got_cyc[0], NB - 1);
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin failures++; $display("FAIL basic_beat%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
`ifdef CPU_DUMP_CHECKSUM_EN
    checks++;
    if (got.size() == NB && got[NB-1] !== beat_t'({4'd9, 16'h0024, 1'b1})) begin
      failures++; $display("FAIL basic_checksum got=%h exp=%h", got[NB-1], beat_t'({4'd9, 16'h0024, 1'b1}));
    end
`endif
  endtask

  task automatic test_backpressure(input int m, input int reps);
    bit to;
    mode = m;
    for (int r = 0; r < reps; r++) begin
      randomize_rf();
      hold_err = 0;
      do_dump(PW'($urandom), to);
      wait_cycle();
      checks += 3;
      if (to) begin failures++; $display("FAIL bp%0d_timeout got=busy exp=idle", m); end
      if (hold_err !== 0) begin failures++; $display("FAIL bp%0d_hold got=%0d exp=0", m, hold_err); end
      if (got.size() !== NB) begin failures++; $display("FAIL bp%0d_count got=%0d exp=%0d", m, got.size(), NB); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin failures++; $display("FAIL bp%0d_beat%0d got=%h exp=%h", m, i, got[i], exp_q[i]); end
      end
    end
    mode = 0;
  endtask

  task automatic test_req_while_busy();
    int n = 0;
    mode = 0;
    randomize_rf();
    pc_in = PW'($urandom);
    build_exp(pc_in);
    got.delete();
    dump_req = 1'b1;
    wait_cycle();
    dump_req = 1'b0;
    wait_cycle();
    wait_cycle();
    dump_req = 1'b1;
    wait_cycle();
    dump_req = 1'b0;
    while (busy && n < 400) begin wait_cycle(); n++; end
    for (int i = 0; i < 4; i++) wait_cycle();
    checks += 2;
    if (got.size() !== NB) begin failures++; $display("FAIL busyreq_count got=%0d exp=%0d", got.size(), NB); end
    if (busy !== 1'b0) begin failures++; $display("FAIL busyreq_restart got=%b exp=0", busy); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin failures++; $display("FAIL busyreq_beat%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_req_held();
    int starts[$];
    int n = 0;
    mode = 0;
    got.delete();
    got_cyc.delete();
    dump_req = 1'b1;
    for (int i = 0; i < 3 * (NB + 1) + 2; i++) wait_cycle();
    dump_req = 1'b0;
    while (busy && n < 400) begin wait_cycle(); n++; end
    foreach (got[i]) if (got[i].tag == 4'd8) starts.push_back(got_cyc[i]);
    checks += 2;
    if (starts.size() < 3) begin failures++; $display("FAIL held_dumps got=%0d exp>=3", starts.size()); end
    if (got.size() % NB != 0) begin failures++; $display("FAIL held_partial got=%0d exp_multiple_of=%0d", got.size(), NB); end
    for (int i = 1; i < starts.size(); i++) begin
      checks++;
      if (starts[i] - starts[i-1] !== NB + 1) begin
        failures++; $display("FAIL held_spacing%0d got=%0d exp=%0d", i, starts[i] - starts[i-1], NB + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    mode = 0;
    randomize_rf();
    pc_in = PW'($urandom);
    dump_req = 1'b1;
    wait_cycle();
    dump_req = 1'b0;
    for (int i = 0; i < 5; i++) wait_cycle();
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (dout_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", dout_valid); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    if (dout_last !== 1'b0)  begin failures++; $display("FAIL rstmid_last got=%b exp=0", dout_last); end
    if (rf_raddr !== 3'd0)   begin failures++; $display("FAIL rstmid_raddr got=%h exp=0", rf_raddr); end
    wait_cycle();
    rst = 1'b0;
    wait_cycle();
    randomize_rf();
    do_dump(PW'($urandom), to);
    checks += 2;
    if (to) begin failures++; $display("FAIL rstmid_timeout got=busy exp=idle"); end
    if (got.size() !== NB) begin failures++; $display("FAIL rstmid_count got=%0d exp=%0d", got.size(), NB); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_beat%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_pc_snapshot();
    int n = 0;
    mode = 2;
    randomize_rf();
    pc_in = 16'h0004;
    got.delete();
    dump_req = 1'b1;
    wait_cycle();
    dump_req = 1'b0;
    pc_in = 16'h0008;
    while (busy && n < 400) begin wait_cycle(); n++; end
    checks += 2;
    if (got.size() !== NB) begin failures++; $display("FAIL pcsnap_count got=%0d exp=%0d", got.size(), NB); end
    if (got.size() > 0 && (got[0].data !== 16'h0004 || got[0].tag !== 4'd8)) begin
      failures++; $display("FAIL pcsnap_data got=%h/%h exp=0004/8", got[0].data, got[0].tag);
    end
    mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    wait_cycle();
    test_backpressure(1, 2);
    test_backpressure(2, 4);
    test_req_while_busy();
    test_req_held();
    test_reset_mid();
    test_pc_snapshot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_state_dump.md
# cpu_state_dump

Responder that streams the pipelined CPU's architectural state (PC and register-file contents R0..R7) over a valid/ready stream on request. It sits beside the register file and program counter, steals the register file's debug read port, and serves the consumer that needs state snapshots: a bench checker, a trace buffer, or a UART bridge. The sequence is PC first, then R0..R7 in order, with `dout_last` on the final beat.

## Interface
- `DATA_W`, default 16: register and beat data width.
- `PC_W`, default 16: program counter width; must be ≤ `DATA_W`.
- `NREGS`, default 8: number of registers dumped; a power of two, ≥ 2.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `dump_req` input, 1 bit: start a dump; sampled only in IDLE.
- `pc_in` input, `PC_W` bits: current `ProgramCounter` PC value.
- `rf_raddr` output, `$clog2(NREGS)` bits: debug read address to the register file.
- `rf_rdata` input, `DATA_W` bits: combinational register-file read data for `rf_raddr`.
- `dout_valid` output, 1 bit: beat available.
- `dout_ready` input, 1 bit: consumer accepts the beat.
- `dout_data` output, `DATA_W` bits: beat payload.
- `dout_tag` output, 4 bits: beat identity. Values are 0..`NREGS`-1 for R*n*, 8 for PC, and 9 for the checksum.
- `dout_last` output, 1 bit: final beat of the dump.
- `busy` output, 1 bit: high from acceptance of `dump_req` through transfer of the last beat.

## Operation
- States:
  - IDLE: `busy`=0, `dout_valid`=0.
  - SEND: `busy`=1 and a beat is held in the output register.
- IDLE → SEND when `dump_req`=1 at a rising edge. That edge loads the PC beat: `dout_data` = `pc_in` zero-extended to `DATA_W`, `dout_tag`=8, `dout_valid`=1. It also clears the index counter to 0.
- Within SEND, a transfer occurs on an edge where `dout_valid` && `dout_ready`.
  - If the beat just transferred is not last, the same edge loads the next beat. Register beat *i* loads `rf_rdata` with `rf_raddr`=*i* driven during that cycle, and gets tag *i*.
  - If it is last, the block returns to IDLE, and `dout_valid`, `busy` and `dout_last` clear.
- `rf_raddr` equals the index of the next register to be loaded. It is 0 in IDLE and during the PC beat.
- While `dout_valid` && !`dout_ready`, the beat is held stable: `dout_data`, `dout_tag` and `dout_last` do not change.
- Snapshot semantics:
  - PC is captured at the request edge.
  - Each register is captured at the edge its beat is loaded. A dump is therefore not atomic against concurrent writeback; the consumer must stall the CPU if it needs atomicity.
- `dump_req` asserted while `busy`=1 is ignored, not queued.
- A `dump_req` held high through the last transfer edge does not restart on that edge. It is sampled again in IDLE on the following edge, which starts a new dump.
- Without the checksum (see Configuration), `dout_last` is high on the R(`NREGS`-1) beat.

## Timing
- Reset values:
  - state IDLE, index 0;
  - `dout_valid`=0, `dout_data`=0, `dout_tag`=0, `dout_last`=0;
  - `busy`=0, `rf_raddr`=0.
- Reset takes effect immediately and asynchronously, including mid-dump. The partial dump is abandoned with no last beat.
- Latency: the PC beat is valid 1 cycle after the request edge.
- Throughput: with `dout_ready` held at 1, one beat per cycle, so `NREGS`+1 beats in `NREGS`+1 cycles (9 for the default).
- Minimum request-to-request spacing is `NREGS`+2 cycles (the IDLE cycle is mandatory).
- No combinational path from `dout_ready` to `dout_valid` or `dout_data`. The only combinational output is `rf_raddr` from the index register, and it is registered-equivalent.

## Configuration
- `CPU_DUMP_CHECKSUM_EN` defined:
  - After R(`NREGS`-1), one extra beat is sent with tag 9.
  - Its data is the XOR of all preceding `dout_data` values of this dump, accumulated at load time.
  - `dout_last` moves to this beat.
  - Throughput and spacing grow by 1 cycle.
- `CPU_DUMP_CHECKSUM_EN` undefined: no tag-9 beat, no accumulator logic.

## Test plan
- Basic dump:
  - Stimulus: defaults, R*n* preloaded with 16'h1000+*n*, `pc_in`=16'h0024, `dout_ready`=1, one-cycle `dump_req`.
  - Response: 9 consecutive beats, tags 8,0..7, data 0024,1000..1007; `dout_last` only on tag 7; `busy` low on the next cycle.
- Back-pressure:
  - Stimulus: `dout_ready` toggled 1,0,0,1 repeatedly.
  - Response: each beat is held stable while not ready, and no beat is lost or duplicated.
- Request while busy:
  - Stimulus: `dump_req` pulsed at beat 3.
  - Response: ignored; exactly 9 beats are sent.
  - Stimulus: `dump_req` held high continuously.
  - Response: dumps repeat with a spacing of 10 cycles.
- Reset mid-dump:
  - Stimulus: `rst` asserted between clock edges during beat 5.
  - Response: `dout_valid`, `busy` and `dout_last` drop immediately with no edge; the next request produces a full 9-beat dump starting at the PC beat.
- Checksum:
  - Stimulus: `CPU_DUMP_CHECKSUM_EN` defined, data as in the basic dump.
  - Response: a 10th beat with tag 9 and data 16'h0024 (0024 ^ (1000^…^1007)), `dout_last` on it.
- PC snapshot:
  - Stimulus: `pc_in` changes from 16'h0004 to 16'h0008 one cycle after the request edge.
  - Response: the PC beat carries 0004.
